// File: rtl/rf_writeback_unit.sv
// Register-file write-back initiator: two producer FIFOs, a round-robin
// arbiter onto a single registered write port, and a per-register busy
// scoreboard for the issue stage.

module rf_wb_fifo #(
   parameter int WIDTH = 37,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             areset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_entry,
   input  logic             pop,
   output logic             full,
   output logic             not_empty,
   output logic [WIDTH-1:0] head
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [WIDTH-1:0] ram [DEPTH];
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic [CW-1:0]    count;

   // entry storage; contents are don't-care until pushed
   always_ff @(posedge clk) begin
      if (push) ram[wptr] <= push_entry;
   end

   // pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + PW'(1);
         if (pop)  rptr <= rptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign full      = (count == DEPTH_C);
   assign not_empty = (count != '0);
   assign head      = ram[rptr];
endmodule

module rf_writeback_unit #(
   parameter int XLEN           = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int REG_COUNT      = 32,
   parameter int FIFO_DEPTH     = 2
) (
   input  logic                      clk,
   input  logic                      areset,
   input  logic                      alu_valid,
   output logic                      alu_ready,
   input  logic [REG_ADDR_WIDTH-1:0] alu_rd,
   input  logic [XLEN-1:0]           alu_data,
   input  logic                      mem_valid,
   output logic                      mem_ready,
   input  logic [REG_ADDR_WIDTH-1:0] mem_rd,
   input  logic [XLEN-1:0]           mem_data,
   input  logic                      iss_valid,
   input  logic [REG_ADDR_WIDTH-1:0] iss_rd,
   input  logic [REG_ADDR_WIDTH-1:0] chk_addr0,
   input  logic [REG_ADDR_WIDTH-1:0] chk_addr1,
   output logic                      chk_busy0,
   output logic                      chk_busy1,
   output logic                      wr_en,
   output logic [REG_ADDR_WIDTH-1:0] wr_addr,
   output logic [XLEN-1:0]           wdata,
   output logic                      idle
);
   localparam int EW = REG_ADDR_WIDTH + XLEN;

   typedef enum logic {
      SRC_ALU = 1'b0,
      SRC_MEM = 1'b1
   } src_e;

   logic                      alu_full, alu_ne, mem_full, mem_ne;
   logic [EW-1:0]             alu_head, mem_head, sel_entry;
   logic                      alu_push, mem_push, pop_alu, pop_mem, any_pop;
   logic [REG_ADDR_WIDTH-1:0] sel_rd;
   logic [XLEN-1:0]           sel_data;
   src_e                      last_grant;
   logic [REG_COUNT-1:0]      busy, busy_nxt;

   // ready is forced low during reset and ignores a same-cycle pop
   assign alu_ready = ~alu_full & ~areset;
   assign mem_ready = ~mem_full & ~areset;
   assign alu_push  = alu_valid & alu_ready;
   assign mem_push  = mem_valid & mem_ready;

   rf_wb_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
      .clk        (clk),
      .areset     (areset),
      .push       (alu_push),
      .push_entry ({alu_rd, alu_data}),
      .pop        (pop_alu),
      .full       (alu_full),
      .not_empty  (alu_ne),
      .head       (alu_head)
   );

   rf_wb_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_mem_fifo (
      .clk        (clk),
      .areset     (areset),
      .push       (mem_push),
      .push_entry ({mem_rd, mem_data}),
      .pop        (pop_mem),
      .full       (mem_full),
      .not_empty  (mem_ne),
      .head       (mem_head)
   );

   // round-robin: on contention the source not granted last time wins
   always_comb begin
      pop_alu   = alu_ne & (~mem_ne | (last_grant == SRC_MEM));
      pop_mem   = mem_ne & ~pop_alu;
      any_pop   = pop_alu | pop_mem;
      sel_entry = pop_alu ? alu_head : mem_head;
      sel_rd    = sel_entry[EW-1:XLEN];
      sel_data  = sel_entry[XLEN-1:0];
   end

   // grant history and registered write port; x0 pops are dropped here
   always_ff @(posedge clk or posedge areset) begin
      if (areset) begin
         last_grant <= SRC_ALU;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wdata      <= '0;
      end else begin
         if (pop_alu)      last_grant <= SRC_ALU;
         else if (pop_mem) last_grant <= SRC_MEM;
         wr_en <= any_pop & (sel_rd != '0);
         if (any_pop && (sel_rd != '0)) begin
            wr_addr <= sel_rd;
            wdata   <= sel_data;
         end
      end
   end

   // scoreboard update: a same-cycle issue to the written register wins
   always_comb begin
      busy_nxt = busy;
      for (int i = 1; i < REG_COUNT; i++) begin
         if (wr_en && (wr_addr == REG_ADDR_WIDTH'(i)))     busy_nxt[i] = 1'b0;
         if (iss_valid && (iss_rd == REG_ADDR_WIDTH'(i)))  busy_nxt[i] = 1'b1;
      end
      busy_nxt[0] = 1'b0;
   end

   // scoreboard state
   always_ff @(posedge clk or posedge areset) begin
      if (areset) busy <= '0;
      else        busy <= busy_nxt;
   end

   // queries see the registered bits only, no bypass of a pending clear
   assign chk_busy0 = (int'(chk_addr0) < REG_COUNT) ? busy[chk_addr0] : 1'b0;
   assign chk_busy1 = (int'(chk_addr1) < REG_COUNT) ? busy[chk_addr1] : 1'b0;

   assign idle = ~alu_ne & ~mem_ne & ~wr_en;
endmodule

// File: tb/tb_rf_writeback_unit.sv
// Bench for rf_writeback_unit: fixed vector table, directed multi-cycle
// sequences and a randomized run against a queue-based reference model.

module tb_rf_writeback_unit;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        areset;
   logic        alu_valid, mem_valid, iss_valid;
   logic        alu_ready, mem_ready;
   logic [4:0]  alu_rd, mem_rd, iss_rd, chk_addr0, chk_addr1;
   logic [31:0] alu_data, mem_data;
   logic        chk_busy0, chk_busy1, wr_en, idle;
   logic [4:0]  wr_addr;
   logic [31:0] wdata;

   int n_tests = 0;
   int n_fail  = 0;

   rf_writeback_unit #(.XLEN(32), .REG_ADDR_WIDTH(5), .REG_COUNT(32), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .areset(areset),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
      .iss_valid(iss_valid), .iss_rd(iss_rd),
      .chk_addr0(chk_addr0), .chk_addr1(chk_addr1), .chk_busy0(chk_busy0), .chk_busy1(chk_busy1),
      .wr_en(wr_en), .wr_addr(wr_addr), .wdata(wdata), .idle(idle)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   // reference model: producer queues, grant history, output and busy set
   ent_t        qa[$];
   ent_t        qm[$];
   ent_t        wrlog[$];
   bit          m_last_mem;
   bit          m_wr_en;
   logic [4:0]  m_wr_addr;
   logic [31:0] m_wdata;
   bit          m_busy[32];
   bit          acc_a, acc_m;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      qa.delete();
      qm.delete();
      m_last_mem = 1'b0;
      m_wr_en    = 1'b0;
      m_wr_addr  = '0;
      m_wdata    = '0;
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      acc_a = 1'b0;
      acc_m = 1'b0;
   endtask

   // compare DUT to model at mid-cycle, then advance the model one edge
   task automatic sample_and_edge();
      ent_t e;
      bit   popped;
      chk("alu_ready", alu_ready, qa.size() < DEPTH);
      chk("mem_ready", mem_ready, qm.size() < DEPTH);
      chk("wr_en", wr_en, m_wr_en);
      chk("wr_addr", wr_addr, m_wr_addr);
      chk("wdata", wdata, m_wdata);
      chk("idle", idle, (qa.size() == 0) && (qm.size() == 0) && !m_wr_en);
      chk("chk_busy0", chk_busy0, m_busy[chk_addr0]);
      chk("chk_busy1", chk_busy1, m_busy[chk_addr1]);
      if (wr_en) wrlog.push_back('{wr_addr, wdata});

      acc_a = alu_valid && (qa.size() < DEPTH);
      acc_m = mem_valid && (qm.size() < DEPTH);
      if (m_wr_en) m_busy[m_wr_addr] = 1'b0;
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      popped = 1'b0;
      if (qa.size() > 0 && (qm.size() == 0 || m_last_mem)) begin
         e = qa.pop_front(); m_last_mem = 1'b0; popped = 1'b1;
      end else if (qm.size() > 0) begin
         e = qm.pop_front(); m_last_mem = 1'b1; popped = 1'b1;
      end
      m_wr_en = popped && (e.rd != 0);
      if (m_wr_en) begin
         m_wr_addr = e.rd;
         m_wdata   = e.data;
      end
      if (acc_a) qa.push_back('{alu_rd, alu_data});
      if (acc_m) qm.push_back('{mem_rd, mem_data});
   endtask

   task automatic tick();
      @(negedge clk);
      sample_and_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
      mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
      iss_valid = 1'b0; iss_rd = '0;
      chk_addr0 = '0;   chk_addr1 = '0;
   endtask

   typedef struct {
      bit          iv;  logic [4:0] ir;
      bit          av;  logic [4:0] ard; logic [31:0] ad;
      bit          mv;  logic [4:0] mrd; logic [31:0] md;
      logic [4:0]  ca;
      bit          e_wr; logic [4:0] e_addr; logic [31:0] e_data;
      bit          e_busy; bit e_idle;
   } vec_t;

   function automatic vec_t mk(int iv, int ir, int av, int ard, logic [31:0] ad,
                               int mv, int mrd, logic [31:0] md, int ca,
                               int ew, int ea, logic [31:0] ed, int eb, int ei);
      vec_t v;
      v.iv = iv[0];   v.ir = 5'(ir);
      v.av = av[0];   v.ard = 5'(ard); v.ad = ad;
      v.mv = mv[0];   v.mrd = 5'(mrd); v.md = md;
      v.ca = 5'(ca);
      v.e_wr = ew[0]; v.e_addr = 5'(ea); v.e_data = ed;
      v.e_busy = eb[0]; v.e_idle = ei[0];
      return v;
   endfunction

   vec_t vt[12];
   int   exp_rd[8];
   int   ai, mi, n_alu_seen;

   initial begin
      // single ALU write to x5 with scoreboard, x0 drop, set/clear collision on x7
      //           iv ir av ard ad            mv mrd md        ca ew ea ed            eb ei
      vt[0]  = mk(1, 5, 0, 0, 32'h0,         0, 0, 32'h0,    5, 0, 0, 32'h0,         0, 1);
      vt[1]  = mk(0, 0, 1, 5, 32'hDEADBEEF,  0, 0, 32'h0,    5, 0, 0, 32'h0,         1, 1);
      vt[2]  = mk(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,    5, 0, 0, 32'h0,         1, 0);
      vt[3]  = mk(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,    5, 1, 5, 32'hDEADBEEF,  1, 0);
      vt[4]  = mk(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,    5, 0, 5, 32'hDEADBEEF,  0, 1);
      vt[5]  = mk(1, 0, 0, 0, 32'h0,         1, 0, 32'h1234, 0, 0, 5, 32'hDEADBEEF,  0, 1);
      vt[6]  = mk(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,    0, 0, 5, 32'hDEADBEEF,  0, 0);
      vt[7]  = mk(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,    0, 0, 5, 32'hDEADBEEF,  0, 1);
      vt[8]  = mk(1, 7, 1, 7, 32'h77,        0, 0, 32'h0,    7, 0, 5, 32'hDEADBEEF,  0, 1);
      vt[9]  = mk(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,    7, 0, 5, 32'hDEADBEEF,  1, 0);
      vt[10] = mk(1, 7, 0, 0, 32'h0,         0, 0, 32'h0,    7, 1, 7, 32'h77,        1, 0);
      vt[11] = mk(0, 0, 0, 0, 32'h0,         0, 0, 32'h0,    7, 0, 7, 32'h77,        1, 1);

      clear_inputs();
      areset = 1'b1;
      model_reset();
      #1;
      chk("reset_alu_ready", alu_ready, 1'b0);
      chk("reset_mem_ready", mem_ready, 1'b0);
      chk("reset_wr_en", wr_en, 1'b0);
      @(negedge clk); @(negedge clk);
      areset = 1'b0;
      @(posedge clk); #1;
      chk("post_reset_wr_addr", wr_addr, 5'd0);
      chk("post_reset_wdata", wdata, 32'd0);
      chk("post_reset_idle", idle, 1'b1);
      chk("post_reset_alu_ready", alu_ready, 1'b1);

      // vector table
      for (int i = 0; i < 12; i++) begin
         iss_valid = vt[i].iv; iss_rd = vt[i].ir;
         alu_valid = vt[i].av; alu_rd = vt[i].ard; alu_data = vt[i].ad;
         mem_valid = vt[i].mv; mem_rd = vt[i].mrd; mem_data = vt[i].md;
         chk_addr0 = vt[i].ca; chk_addr1 = 5'd0;
         @(negedge clk);
         chk($sformatf("vec%0d_wr_en", i), wr_en, vt[i].e_wr);
         chk($sformatf("vec%0d_wr_addr", i), wr_addr, vt[i].e_addr);
         chk($sformatf("vec%0d_wdata", i), wdata, vt[i].e_data);
         chk($sformatf("vec%0d_busy", i), chk_busy0, vt[i].e_busy);
         chk($sformatf("vec%0d_idle", i), idle, vt[i].e_idle);
         sample_and_edge();
         @(posedge clk); #1;
      end
      clear_inputs();
      tick();

      // contention: both sources push every cycle; last grant starts at ALU
      exp_rd = '{11, 1, 12, 2, 13, 3, 14, 4};
      wrlog.delete();
      ai = 0; mi = 0;
      for (int c = 0; c < 14; c++) begin
         alu_valid = (ai < 4); alu_rd = 5'(ai + 1);  alu_data = 32'hA000_0000 + 32'(ai);
         mem_valid = (mi < 4); mem_rd = 5'(mi + 11); mem_data = 32'hB000_0000 + 32'(mi);
         tick();
         if (acc_a) ai++;
         if (acc_m) mi++;
      end
      clear_inputs();
      chk("contention_count", wrlog.size(), 8);
      for (int i = 0; i < 8 && i < wrlog.size(); i++) begin
         chk($sformatf("contention_rd%0d", i), wrlog[i].rd, exp_rd[i]);
         chk($sformatf("contention_data%0d", i), wrlog[i].data,
             (exp_rd[i] > 10) ? 32'hB000_0000 + 32'(exp_rd[i] - 11)
                              : 32'hA000_0000 + 32'(exp_rd[i] - 1));
      end

      // backpressure: three ALU entries held against a saturated memory source
      wrlog.delete();
      ai = 0; mi = 0;
      for (int c = 0; c < 20; c++) begin
         alu_valid = (ai < 3); alu_rd = 5'(ai + 1);  alu_data = 32'hC0 + 32'(ai);
         mem_valid = (mi < 6); mem_rd = 5'(mi + 21); mem_data = 32'hD0 + 32'(mi);
         tick();
         if (acc_a) ai++;
         if (acc_m) mi++;
      end
      clear_inputs();
      n_alu_seen = 0;
      foreach (wrlog[i]) begin
         if (wrlog[i].rd < 5'd4) begin
            chk($sformatf("bp_alu_order%0d", n_alu_seen), wrlog[i].data, 32'hC0 + 32'(n_alu_seen));
            n_alu_seen++;
         end
      end
      chk("bp_alu_count", n_alu_seen, 3);
      chk("bp_total_count", wrlog.size(), 9);

      // reset mid-stream with entries queued and a write on the port
      iss_valid = 1'b1; iss_rd = 5'd3;
      alu_valid = 1'b1; alu_rd = 5'd3;  alu_data = 32'hA3;
      mem_valid = 1'b1; mem_rd = 5'd13; mem_data = 32'hB13;
      tick();
      clear_inputs();
      tick();
      chk("pre_reset_wr_en", wr_en, 1'b1);
      #1 areset = 1'b1;
      #1;
      chk("midreset_wr_en", wr_en, 1'b0);
      chk("midreset_alu_ready", alu_ready, 1'b0);
      chk("midreset_mem_ready", mem_ready, 1'b0);
      chk("midreset_wr_addr", wr_addr, 5'd0);
      @(negedge clk); @(negedge clk);
      areset = 1'b0;
      model_reset();
      #1;
      chk("release_alu_ready", alu_ready, 1'b1);
      chk("release_mem_ready", mem_ready, 1'b1);
      chk("release_idle", idle, 1'b1);
      for (int a = 0; a < 32; a++) begin
         chk_addr0 = 5'(a);
         #1;
         chk($sformatf("release_busy%0d", a), chk_busy0, 1'b0);
      end
      chk_addr0 = '0;
      @(posedge clk); #1;

      // randomized traffic; ALU and memory use disjoint destination ranges
      acc_a = 1'b0; acc_m = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if (!alu_valid || acc_a) begin
            alu_valid = ($urandom_range(0, 99) < 60);
            alu_rd    = 5'($urandom_range(0, 15));
            alu_data  = $urandom;
         end
         if (!mem_valid || acc_m) begin
            mem_valid = ($urandom_range(0, 99) < 60);
            mem_rd    = 5'($urandom_range(15, 31));
            if (mem_rd == 5'd15) mem_rd = 5'd0;
            mem_data  = $urandom;
         end
         iss_valid = $urandom_range(0, 1) == 1;
         iss_rd    = 5'($urandom_range(0, 31));
         chk_addr0 = 5'($urandom_range(0, 31));
         chk_addr1 = 5'($urandom_range(0, 31));
         tick();
      end
      clear_inputs();
      for (int c = 0; c < 6; c++) tick();
      chk("final_idle", idle, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
